// File: rtl/gb_pkg.sv
// gb_pkg -- state encoding, flag layout, opcode and register-index constants for the LR35902-subset core.
// Optional JR e8 support is compiled in when DP_JR_EN is defined. Rev 1.0
`default_nettype none

package gb_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    IMM_LO  = 3'd2,
    IMM_HI  = 3'd3,
    EXECUTE = 3'd4,
    HALT    = 3'd5
  } gb_state_t;

  typedef struct packed {
    logic Z;
    logic N;
    logic H;
    logic C;
  } gb_flags_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h76;
  localparam logic [7:0] OP_JP   = 8'hC3;
  localparam logic [7:0] OP_JR   = 8'h18;

  localparam logic [2:0] RI_B  = 3'd0;
  localparam logic [2:0] RI_C  = 3'd1;
  localparam logic [2:0] RI_D  = 3'd2;
  localparam logic [2:0] RI_E  = 3'd3;
  localparam logic [2:0] RI_H  = 3'd4;
  localparam logic [2:0] RI_L  = 3'd5;
  localparam logic [2:0] RI_HL = 3'd6;
  localparam logic [2:0] RI_A  = 3'd7;

  function automatic logic is_ld_imm(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[2:0] == 3'b110);
  endfunction

  // Opcodes that pull at least one operand byte after the opcode.
  function automatic logic needs_imm(input logic [7:0] op);
`ifdef DP_JR_EN
    return is_ld_imm(op) || (op == OP_JP) || (op == OP_JR);
`else
    return is_ld_imm(op) || (op == OP_JP);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_control_path.sv
// control_path -- multi-cycle sequencer: FETCH, DECODE, IMM_LO, IMM_HI, EXECUTE, HALT.
// Honours DP_JR_EN through gb_pkg::needs_imm. Rev 1.0
`default_nettype none

module control_path
  import gb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  output logic [2:0] state
);

  gb_state_t curr_state;
  gb_state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      curr_state <= FETCH;
    end else begin
      curr_state <= next_state;
    end
  end

  always_comb begin
    next_state = curr_state;
    case (curr_state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        if (opcode == OP_HALT) begin
          next_state = HALT;
        end else if (needs_imm(opcode)) begin
          next_state = IMM_LO;
        end else begin
          next_state = EXECUTE;
        end
      end
      IMM_LO:  next_state = (opcode == OP_JP) ? IMM_HI : EXECUTE;
      IMM_HI:  next_state = EXECUTE;
      EXECUTE: next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign state = curr_state;

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// datapath -- LR35902-subset CPU: register file, ALU and byte memory around the control_path sequencer.
// Define DP_JR_EN to enable JR e8; otherwise 0x18 executes as a 3-cycle NOP. Rev 1.0
`default_nettype none

module datapath
  import gb_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input logic clk,
  input logic rst
);

  localparam int MEM_SIZE = 1 << MEM_AW;

  logic [15:0] PC;
  logic [15:0] pc_d;
  logic [7:0]  IR;
  logic [7:0]  ir_d;
  logic [7:0]  imm_lo;
  logic [7:0]  imm_lo_d;
  logic [7:0]  imm_hi;
  logic [7:0]  imm_hi_d;
  logic [7:0]  A, B, C, D, E, H, L;
  gb_flags_t   F;
  gb_flags_t   flags_d;
  logic [7:0]  mem [MEM_SIZE];

  logic [2:0]  state_raw;
  gb_state_t   state;

  logic [MEM_AW-1:0] pc_addr;
  logic [MEM_AW-1:0] hl_addr;
  logic [7:0]        hl_data;
  logic [7:0]        src_val;
  logic [7:0]        dst_val;

  logic              wr_en;
  logic [2:0]        wr_idx;
  logic [7:0]        wr_val;
  logic [8:0]        alu_wide;
  logic [4:0]        alu_nib;

  control_path cp (
    .clk    (clk),
    .rst    (rst),
    .opcode (IR),
    .state  (state_raw)
  );

  assign state   = gb_state_t'(state_raw);
  assign pc_addr = MEM_AW'(PC);
  assign hl_addr = MEM_AW'({H, L});
  assign hl_data = mem[hl_addr];

  // Operand fetch: sss field is the source, ddd/rrr field the destination.
  always_comb begin
    src_val = A;
    dst_val = A;
    case (IR[2:0])
      RI_B:    src_val = B;
      RI_C:    src_val = C;
      RI_D:    src_val = D;
      RI_E:    src_val = E;
      RI_H:    src_val = H;
      RI_L:    src_val = L;
      RI_HL:   src_val = hl_data;
      default: src_val = A;
    endcase
    case (IR[5:3])
      RI_B:    dst_val = B;
      RI_C:    dst_val = C;
      RI_D:    dst_val = D;
      RI_E:    dst_val = E;
      RI_H:    dst_val = H;
      RI_L:    dst_val = L;
      RI_HL:   dst_val = hl_data;
      default: dst_val = A;
    endcase
  end

  always_comb begin
    pc_d     = PC;
    ir_d     = IR;
    imm_lo_d = imm_lo;
    imm_hi_d = imm_hi;
    flags_d  = F;
    wr_en    = 1'b0;
    wr_idx   = IR[5:3];
    wr_val   = 8'h00;
    alu_wide = 9'h000;
    alu_nib  = 5'h00;

    case (state)
      FETCH: begin
        ir_d = mem[pc_addr];
        pc_d = PC + 16'd1;
      end
      IMM_LO: begin
        imm_lo_d = mem[pc_addr];
        pc_d     = PC + 16'd1;
      end
      IMM_HI: begin
        imm_hi_d = mem[pc_addr];
        pc_d     = PC + 16'd1;
      end
      EXECUTE: begin
        casez (IR)
          OP_NOP: ;
          OP_JP:  pc_d = {imm_hi, imm_lo};
`ifdef DP_JR_EN
          OP_JR:  pc_d = PC + {{8{imm_lo[7]}}, imm_lo};
`endif
          8'b00???110: begin
            wr_en  = 1'b1;
            wr_val = imm_lo;
          end
          8'b00???100: begin
            wr_en     = 1'b1;
            wr_val    = dst_val + 8'd1;
            flags_d.Z = (wr_val == 8'h00);
            flags_d.N = 1'b0;
            flags_d.H = (dst_val[3:0] == 4'hF);
          end
          8'b00???101: begin
            wr_en     = 1'b1;
            wr_val    = dst_val - 8'd1;
            flags_d.Z = (wr_val == 8'h00);
            flags_d.N = 1'b1;
            flags_d.H = (dst_val[3:0] == 4'h0);
          end
          8'b01??????: begin
            wr_en  = 1'b1;
            wr_val = src_val;
          end
          8'b10000???: begin
            alu_wide  = {1'b0, A} + {1'b0, src_val};
            alu_nib   = {1'b0, A[3:0]} + {1'b0, src_val[3:0]};
            wr_en     = 1'b1;
            wr_idx    = RI_A;
            wr_val    = alu_wide[7:0];
            flags_d.Z = (alu_wide[7:0] == 8'h00);
            flags_d.N = 1'b0;
            flags_d.H = alu_nib[4];
            flags_d.C = alu_wide[8];
          end
          8'b10010???: begin
            // Bit 8/bit 4 of the widened difference is the borrow out.
            alu_wide  = {1'b0, A} - {1'b0, src_val};
            alu_nib   = {1'b0, A[3:0]} - {1'b0, src_val[3:0]};
            wr_en     = 1'b1;
            wr_idx    = RI_A;
            wr_val    = alu_wide[7:0];
            flags_d.Z = (alu_wide[7:0] == 8'h00);
            flags_d.N = 1'b1;
            flags_d.H = alu_nib[4];
            flags_d.C = alu_wide[8];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC     <= 16'h0000;
      IR     <= 8'h00;
      imm_lo <= 8'h00;
      imm_hi <= 8'h00;
      A      <= 8'h00;
      B      <= 8'h00;
      C      <= 8'h00;
      D      <= 8'h00;
      E      <= 8'h00;
      H      <= 8'h00;
      L      <= 8'h00;
      F      <= '0;
    end else begin
      PC     <= pc_d;
      IR     <= ir_d;
      imm_lo <= imm_lo_d;
      imm_hi <= imm_hi_d;
      F      <= flags_d;
      if (wr_en) begin
        case (wr_idx)
          RI_B:    B <= wr_val;
          RI_C:    C <= wr_val;
          RI_D:    D <= wr_val;
          RI_E:    E <= wr_val;
          RI_H:    H <= wr_val;
          RI_L:    L <= wr_val;
          RI_A:    A <= wr_val;
          default: ;
        endcase
      end
    end
  end

  // Memory contents survive reset; only (HL) writes from EXECUTE land here.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && (wr_idx == RI_HL)) begin
      mem[hl_addr] <= wr_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// tb_datapath -- vector table, hand-written corner sequences and random programs against an instruction-level model.
`default_nettype none
`timescale 1ns/1ps

module tb_datapath;
  import gb_pkg::*;

`ifdef DP_JR_EN
  localparam bit JR_ON = 1'b1;
`else
  localparam bit JR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath #(.MEM_AW(8)) dut (
    .clk (clk),
    .rst (rst)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] prog;
    logic [7:0]  a;
    logic [3:0]  f;
    logic [15:0] pc;
    int          cyc;
  } vec_t;

  vec_t        vecs [10];
  logic [7:0]  img [256];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_r [8];
  logic        mz, mn, mh, mc;
  logic [15:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_reset();
    rst = 1'b1;
    step(1);
  endtask

  task automatic end_reset();
    step(1);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.mem[i] = 8'h00;
  endtask

  task automatic run_to_halt(input string name, output int cyc);
    cyc = 0;
    while (dut.cp.curr_state != HALT && cyc < 500) begin
      step(1);
      cyc++;
    end
    if (dut.cp.curr_state != HALT) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_halt_timeout: state %0d after %0d cycles, expected HALT", name, dut.cp.curr_state, cyc);
    end
  endtask

  // Instruction-level reference: H is pinned to 0 by the generator, so (HL) is just mem[L].
  function automatic logic [7:0] m_get(input logic [2:0] i);
    if (i == 3'd6) return m_mem[m_r[5]];
    return m_r[i];
  endfunction

  task automatic m_set(input logic [2:0] i, input logic [7:0] v);
    if (i == 3'd6) m_mem[m_r[5]] = v;
    else m_r[i] = v;
  endtask

  task automatic run_model(output int cyc);
    logic [7:0] op, lo, hi;
    logic [2:0] d, si;
    int         a, s, v, res;
    bit         done;
    cyc  = 0;
    done = 1'b0;
    m_pc = 16'h0000;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    {mz, mn, mh, mc} = 4'b0000;
    for (int n = 0; n < 500 && !done; n++) begin
      op   = m_mem[m_pc[7:0]];
      m_pc = m_pc + 16'd1;
      d    = op[5:3];
      si   = op[2:0];
      if (op == 8'h76) begin
        cyc += 2;
        done = 1'b1;
      end else if (op == 8'hC3) begin
        lo   = m_mem[m_pc[7:0]];
        hi   = m_mem[m_pc[7:0] + 8'd1];
        m_pc = {hi, lo};
        cyc += 5;
      end else if (op == 8'h18 && JR_ON) begin
        lo   = m_mem[m_pc[7:0]];
        m_pc = 16'(int'(m_pc) + 1 + ((lo > 127) ? int'(lo) - 256 : int'(lo)));
        cyc += 4;
      end else if (op[7:6] == 2'b00 && si == 3'd6) begin
        m_set(d, m_mem[m_pc[7:0]]);
        m_pc = m_pc + 16'd1;
        cyc += 4;
      end else begin
        cyc += 3;
        if (op[7:6] == 2'b01) begin
          m_set(d, m_get(si));
        end else if (op[7:6] == 2'b00 && si == 3'd4) begin
          v   = int'(m_get(d));
          res = (v + 1) % 256;
          m_set(d, 8'(res));
          mz = (res == 0); mn = 1'b0; mh = ((v % 16) == 15);
        end else if (op[7:6] == 2'b00 && si == 3'd5) begin
          v   = int'(m_get(d));
          res = (v + 255) % 256;
          m_set(d, 8'(res));
          mz = (res == 0); mn = 1'b1; mh = ((v % 16) == 0);
        end else if (op[7:3] == 5'b10000) begin
          a   = int'(m_r[7]);
          s   = int'(m_get(si));
          res = (a + s) % 256;
          m_r[7] = 8'(res);
          mz = (res == 0); mn = 1'b0; mh = ((a % 16) + (s % 16) > 15); mc = (a + s > 255);
        end else if (op[7:3] == 5'b10010) begin
          a   = int'(m_r[7]);
          s   = int'(m_get(si));
          res = (a - s + 256) % 256;
          m_r[7] = 8'(res);
          mz = (res == 0); mn = 1'b1; mh = ((s % 16) > (a % 16)); mc = (s > a);
        end
      end
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // prog bytes MSB first; expected A, {Z,N,H,C}, PC at HALT, cycles from reset release to HALT.
    vecs[0] = '{64'h3E053C76_00000000, 8'h06, 4'b0000, 16'h0004, 9};
    vecs[1] = '{64'h3EFF0601_80760000, 8'h00, 4'b1011, 16'h0006, 13};
    vecs[2] = '{64'h3E100601_90760000, 8'h0F, 4'b0110, 16'h0006, 13};
    vecs[3] = '{64'h3E003D76_00000000, 8'hFF, 4'b0110, 16'h0004, 9};
    vecs[4] = '{64'h3E0F3C76_00000000, 8'h10, 4'b0010, 16'h0004, 9};
    vecs[5] = '{64'h3E050605_90760000, 8'h00, 4'b1100, 16'h0006, 13};
    vecs[6] = '{64'h26002E20_36AB7E76, 8'hAB, 4'b0000, 16'h0008, 17};
    vecs[7] = '{64'h3EFF0601_803C7600, 8'h01, 4'b0001, 16'h0007, 16};
    vecs[8] = '{64'h3E070776_00000000, 8'h07, 4'b0000, 16'h0004, 9};
    vecs[9] = '{64'h3E010602_90760000, 8'hFF, 4'b0111, 16'h0006, 13};

    for (int i = 0; i < 10; i++) begin
      begin_reset();
      clear_mem();
      for (int b = 0; b < 8; b++) dut.mem[b] = vecs[i].prog[63 - 8*b -: 8];
      end_reset();
      run_to_halt($sformatf("vec%0d", i), cyc);
      chk($sformatf("vec%0d_A", i), dut.A, vecs[i].a);
      chk($sformatf("vec%0d_flags", i), {dut.F.Z, dut.F.N, dut.F.H, dut.F.C}, vecs[i].f);
      chk($sformatf("vec%0d_PC", i), dut.PC, vecs[i].pc);
      chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
    end

    // Reset out of a halted, non-zero state, then NOPs.
    begin_reset();
    clear_mem();
    end_reset();
    chk("reset_PC", dut.PC, 16'h0000);
    chk("reset_IR", dut.IR, 8'h00);
    chk("reset_state", dut.cp.curr_state, FETCH);
    chk("reset_A", dut.A, 8'h00);
    chk("reset_flags", {dut.F.Z, dut.F.N, dut.F.H, dut.F.C}, 4'b0000);
    step(3);
    chk("nop_PC", dut.PC, 16'h0001);
    chk("nop_state", dut.cp.curr_state, FETCH);

    // HALT holds everything.
    begin_reset();
    clear_mem();
    dut.mem[0] = 8'h3E; dut.mem[1] = 8'h05; dut.mem[2] = 8'h3C; dut.mem[3] = 8'h76;
    end_reset();
    run_to_halt("halt_hold", cyc);
    chk("halt_PC", dut.PC, 16'h0004);
    step(20);
    chk("halt_PC_after20", dut.PC, 16'h0004);
    chk("halt_A_after20", dut.A, 8'h06);
    chk("halt_state_after20", dut.cp.curr_state, HALT);

    // JP a16 timing.
    begin_reset();
    clear_mem();
    dut.mem[0] = 8'hC3; dut.mem[1] = 8'h10; dut.mem[2] = 8'h00; dut.mem[16] = 8'h76;
    end_reset();
    step(5);
    chk("jp_PC", dut.PC, 16'h0010);
    chk("jp_state", dut.cp.curr_state, FETCH);
    step(2);
    chk("jp_halt_state", dut.cp.curr_state, HALT);
    chk("jp_halt_PC", dut.PC, 16'h0011);

    // JR -2 loops on itself when enabled, otherwise 0x18 is a plain NOP.
    begin_reset();
    clear_mem();
    dut.mem[0] = 8'h18; dut.mem[1] = 8'hFE;
    end_reset();
    for (int k = 1; k <= 3; k++) begin
      if (JR_ON) begin
        step(4);
        chk($sformatf("jr_PC_iter%0d", k), dut.PC, 16'h0000);
      end else begin
        step(3);
        chk($sformatf("jr_nop_PC_iter%0d", k), dut.PC, 16'(k));
      end
      chk($sformatf("jr_state_iter%0d", k), dut.cp.curr_state, FETCH);
    end

    // Reset in the middle of a JP operand fetch.
    begin_reset();
    clear_mem();
    dut.mem[0] = 8'hC3; dut.mem[1] = 8'h10; dut.mem[2] = 8'h00; dut.mem[16] = 8'h76;
    end_reset();
    step(3);
    chk("abort_pre_state", dut.cp.curr_state, IMM_HI);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_PC", dut.PC, 16'h0000);
    chk("abort_state", dut.cp.curr_state, FETCH);
    chk("abort_A", dut.A, 8'h00);

    // Random straight-line programs; H:L = 00:C0 so (HL) never overlaps code.
    for (int t = 0; t < 25; t++) begin
      int pos, n, r, mcyc, dcyc;
      logic [2:0] d, s;
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h26; img[1] = 8'h00; img[2] = 8'h2E; img[3] = 8'hC0;
      pos = 4;
      n = int'($urandom_range(4, 12));
      for (int k = 0; k < n; k++) begin
        r = int'($urandom_range(0, 5));
        d = (r < 4) ? 3'(r) : 3'(r + 2);
        s = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 6))
          0: begin img[pos] = {2'b00, d, 3'b110}; img[pos+1] = 8'($urandom); pos += 2; end
          1: begin img[pos] = {2'b01, d, ((d == 3'd6 && s == 3'd6) ? 3'd7 : s)}; pos += 1; end
          2: begin img[pos] = {2'b00, d, 3'b100}; pos += 1; end
          3: begin img[pos] = {2'b00, d, 3'b101}; pos += 1; end
          4: begin img[pos] = {5'b10000, s}; pos += 1; end
          5: begin img[pos] = {5'b10010, s}; pos += 1; end
          default: begin img[pos] = (s[0]) ? 8'hA8 : 8'h07; pos += 1; end
        endcase
      end
      img[pos] = 8'h76;
      img[8'hC0] = 8'($urandom);
      begin_reset();
      for (int i = 0; i < 256; i++) begin
        dut.mem[i] = img[i];
        m_mem[i]   = img[i];
      end
      end_reset();
      run_model(mcyc);
      run_to_halt($sformatf("rnd%0d", t), dcyc);
      chk($sformatf("rnd%0d_A", t), dut.A, m_r[7]);
      chk($sformatf("rnd%0d_B", t), dut.B, m_r[0]);
      chk($sformatf("rnd%0d_C", t), dut.C, m_r[1]);
      chk($sformatf("rnd%0d_D", t), dut.D, m_r[2]);
      chk($sformatf("rnd%0d_E", t), dut.E, m_r[3]);
      chk($sformatf("rnd%0d_H", t), dut.H, m_r[4]);
      chk($sformatf("rnd%0d_L", t), dut.L, m_r[5]);
      chk($sformatf("rnd%0d_flags", t), {dut.F.Z, dut.F.N, dut.F.H, dut.F.C}, {mz, mn, mh, mc});
      chk($sformatf("rnd%0d_PC", t), dut.PC, m_pc);
      chk($sformatf("rnd%0d_memHL", t), dut.mem[8'hC0], m_mem[8'hC0]);
      chk($sformatf("rnd%0d_cycles", t), dcyc, mcyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
